// File: rtl/present_masked_pkg.sv
// -----------------------------------------------------------------------------
// present_masked_pkg
// Shared constants, types and masked-gadget helpers for the 3-share masked
// PRESENT datapath.
//   SBOX_LAT      pipeline depth of one masked S-box (cycles)
//   NIBBLE_W      S-box width
//   RND_PER_SBOX  fresh random bits consumed per S-box per nibble
//   STATE_W       PRESENT state width
//   layer_state_e control FSM states of the substitution layer
//   dom_and       3-share AND with cross-domain remasking (3 random bits)
//   ti_and        3-share non-complete AND, no fresh randomness
// -----------------------------------------------------------------------------
package present_masked_pkg;

  localparam int SBOX_LAT     = 3;
  localparam int NIBBLE_W     = 4;
  localparam int RND_PER_SBOX = 8;
  localparam int STATE_W      = 64;
  localparam int NIBBLES      = STATE_W / NIBBLE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } layer_state_e;

  // A 64-bit state viewed as 16 nibbles; nibble i is bits [4i+3:4i].
  typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

  // Vectors below are indexed by share: bit 0 = share 1, bit 2 = share 3.
  // Cross products a_i*b_j are blinded by r_ij, shared by the two domains
  // so the masks cancel in the XOR of the three result shares.
  // r[0] = r_12, r[1] = r_13, r[2] = r_23.
  function automatic logic [2:0] dom_and(input logic [2:0] a,
                                         input logic [2:0] b,
                                         input logic [2:0] r);
    logic [2:0] z;
    z[0] = (a[0] & b[0]) ^ ((a[0] & b[1]) ^ r[0]) ^ ((a[0] & b[2]) ^ r[1]);
    z[1] = (a[1] & b[1]) ^ ((a[1] & b[0]) ^ r[0]) ^ ((a[1] & b[2]) ^ r[2]);
    z[2] = (a[2] & b[2]) ^ ((a[2] & b[0]) ^ r[1]) ^ ((a[2] & b[1]) ^ r[2]);
    return z;
  endfunction

  // Output share i only sees input shares i and i+1 (mod 3), so no single
  // output share depends on all three input shares.
  function automatic logic [2:0] ti_and(input logic [2:0] a,
                                        input logic [2:0] b);
    logic [2:0] z;
    z[0] = (a[0] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[0]);
    z[1] = (a[1] & b[1]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
    z[2] = (a[2] & b[2]) ^ (a[2] & b[0]) ^ (a[0] & b[2]);
    return z;
  endfunction

endpackage

// File: rtl/present_sbox_3sh.sv
// -----------------------------------------------------------------------------
// present_sbox_3sh
// One 3-share masked PRESENT S-box, fully pipelined, latency SBOX_LAT (3),
// one nibble per cycle.
//   clk, rst_n             clock, synchronous active-low reset
//   in_sh1..in_sh3  [3:0]  input nibble shares
//   rnd             [7:0]  fresh randomness, sampled with the input nibble
//   out_sh1..out_sh3[3:0]  output shares, valid SBOX_LAT cycles after input
//
// The cubic S-box is built from two quadratic layers:
//   F: masked products p01 = x0&x1 and p23 = x2&x3 (6 random bits), plus a
//      refresh of the linear shares (2 random bits)
//   G: every output bit is a sum of linear terms, p01/p23 and products of
//      two registered values, which yields the three cubic monomials
//      x0x1x2 = p01*x2, x0x1x3 = p01*x3, x0x2x3 = p23*x0.
// The ANF used (x0 = LSB):
//   y0 = x0+x2+x3+x1x2
//   y1 = x1+x3+x1x3+x2x3+x0x1x2+x0x1x3+x0x2x3
//   y2 = 1+x2+x3+x0x1+x0x3+x1x3+x0x1x3+x0x2x3
//   y3 = 1+x0+x1+x3+x1x2+x0x1x2+x0x1x3+x0x2x3
// -----------------------------------------------------------------------------
module present_sbox_3sh
  import present_masked_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NIBBLE_W-1:0]     in_sh1,
  input  logic [NIBBLE_W-1:0]     in_sh2,
  input  logic [NIBBLE_W-1:0]     in_sh3,
  input  logic [RND_PER_SBOX-1:0] rnd,
  output logic [NIBBLE_W-1:0]     out_sh1,
  output logic [NIBBLE_W-1:0]     out_sh2,
  output logic [NIBBLE_W-1:0]     out_sh3
);

  // Output affine: the constant 1 of y2 and y3 is added to share 1 only.
  localparam logic [NIBBLE_W-1:0] OUT_CONST = 4'b1100;

  // Stage 0: input affine layer. The decomposition above works directly on
  // the input bits, so this stage is the identity and only registers.
  logic [NIBBLE_W-1:0]     s0_x1, s0_x2, s0_x3;
  logic [RND_PER_SBOX-1:0] s0_rnd;

  // Stage 1: outputs of F.
  logic [NIBBLE_W-1:0]     s1_x1, s1_x2, s1_x3;
  logic [2:0]              s1_p01, s1_p23;

  // Stage 2: outputs of G (before the output constant).
  logic [NIBBLE_W-1:0]     s2_y1, s2_y2, s2_y3;

  // F inputs, share vectors per input bit.
  logic [2:0] f_x0, f_x1, f_x2, f_x3;
  logic [NIBBLE_W-1:0] f_refresh;

  assign f_x0 = {s0_x3[0], s0_x2[0], s0_x1[0]};
  assign f_x1 = {s0_x3[1], s0_x2[1], s0_x1[1]};
  assign f_x2 = {s0_x3[2], s0_x2[2], s0_x1[2]};
  assign f_x3 = {s0_x3[3], s0_x2[3], s0_x1[3]};
  // Same mask on shares 1 and 2 keeps the unshared value unchanged.
  assign f_refresh = {s0_rnd[7], s0_rnd[6], s0_rnd[7], s0_rnd[6]};

  // G inputs.
  logic [2:0] g_x0, g_x1, g_x2, g_x3;
  logic [2:0] t12, t13, t03, c012, c013, c023;
  logic [2:0] y0v, y1v, y2v, y3v;

  assign g_x0 = {s1_x3[0], s1_x2[0], s1_x1[0]};
  assign g_x1 = {s1_x3[1], s1_x2[1], s1_x1[1]};
  assign g_x2 = {s1_x3[2], s1_x2[2], s1_x1[2]};
  assign g_x3 = {s1_x3[3], s1_x2[3], s1_x1[3]};

  always_comb begin
    t12  = ti_and(g_x1, g_x2);
    t13  = ti_and(g_x1, g_x3);
    t03  = ti_and(g_x0, g_x3);
    c012 = ti_and(s1_p01, g_x2);
    c013 = ti_and(s1_p01, g_x3);
    c023 = ti_and(s1_p23, g_x0);
    y0v  = g_x0 ^ g_x2 ^ g_x3 ^ t12;
    y1v  = g_x1 ^ g_x3 ^ t13 ^ s1_p23 ^ c012 ^ c013 ^ c023;
    y2v  = g_x2 ^ g_x3 ^ s1_p01 ^ t03 ^ t13 ^ c013 ^ c023;
    y3v  = g_x0 ^ g_x1 ^ g_x3 ^ t12 ^ c012 ^ c013 ^ c023;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_x1  <= '0;
      s0_x2  <= '0;
      s0_x3  <= '0;
      s0_rnd <= '0;
      s1_x1  <= '0;
      s1_x2  <= '0;
      s1_x3  <= '0;
      s1_p01 <= '0;
      s1_p23 <= '0;
      s2_y1  <= '0;
      s2_y2  <= '0;
      s2_y3  <= '0;
    end else begin
      s0_x1  <= in_sh1;
      s0_x2  <= in_sh2;
      s0_x3  <= in_sh3;
      s0_rnd <= rnd;

      s1_x1  <= s0_x1 ^ f_refresh;
      s1_x2  <= s0_x2 ^ f_refresh;
      s1_x3  <= s0_x3;
      s1_p01 <= dom_and(f_x0, f_x1, s0_rnd[2:0]);
      s1_p23 <= dom_and(f_x2, f_x3, s0_rnd[5:3]);

      s2_y1  <= {y3v[0], y2v[0], y1v[0], y0v[0]};
      s2_y2  <= {y3v[1], y2v[1], y1v[1], y0v[1]};
      s2_y3  <= {y3v[2], y2v[2], y1v[2], y0v[2]};
    end
  end

  assign out_sh1 = s2_y1 ^ OUT_CONST;
  assign out_sh2 = s2_y2;
  assign out_sh3 = s2_y3;

endmodule

// File: rtl/present_sbox_layer_3sh.sv
// -----------------------------------------------------------------------------
// present_sbox_layer_3sh
// 3-share masked PRESENT substitution layer. The 64-bit shared state is
// pushed through NUM_SBOX masked S-boxes in CHUNKS = 16/NUM_SBOX chunks and
// the shared result is assembled in the output registers.
//   NUM_SBOX            parallel S-box instances: 1, 2, 4, 8 or 16
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin a layer (accepted only in IDLE, not in done cycle)
//   in_sh1..in_sh3      input shares, captured when start is accepted
//   rnd                 8 random bits per instance, consumed while rnd_req=1
//   rnd_req             high in each ISSUE cycle
//   busy                high from the cycle after acceptance through done
//   done                one-cycle pulse, out_sh1..3 hold the full result
//   out_sh1..out_sh3    output shares, held until the next accepted start
//   state_dbg           current FSM state
// Build option PRESENT_SBOX_LAYER_ZEROIZE_EN: clear the outputs on accept and
// feed zeros into the S-boxes outside ISSUE.
//
// Handshake: start is a request sampled on the rising edge while the FSM is
// IDLE and done is low; it is then ignored until the cycle after done. If
// start is accepted in cycle T, rnd_req is high in T+1..T+CHUNKS, done is high
// in T+CHUNKS+4 and busy is high in T+1..T+CHUNKS+4.
// -----------------------------------------------------------------------------
module present_sbox_layer_3sh
  import present_masked_pkg::*;
#(
  parameter int NUM_SBOX = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [STATE_W-1:0]           in_sh1,
  input  logic [STATE_W-1:0]           in_sh2,
  input  logic [STATE_W-1:0]           in_sh3,
  input  logic [8*NUM_SBOX-1:0]        rnd,
  output logic                         rnd_req,
  output logic                         busy,
  output logic                         done,
  output logic [STATE_W-1:0]           out_sh1,
  output logic [STATE_W-1:0]           out_sh2,
  output logic [STATE_W-1:0]           out_sh3,
  output layer_state_e                 state_dbg
);

  localparam int CHUNKS = NIBBLES / NUM_SBOX;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [1:0]       LAST_DRAIN = 2'(SBOX_LAT - 1);

  layer_state_e state;
  logic [CNT_W-1:0] issue_cnt;
  logic [1:0]       drain_cnt;

  nib_vec_t st_sh1, st_sh2, st_sh3;
  nib_vec_t out_r1, out_r2, out_r3;

  // Write-back tracker: a chunk index travelling alongside the S-box pipe so
  // the result lands in the nibbles it was read from.
  logic [SBOX_LAT-1:0]            wb_vld;
  logic [SBOX_LAT-1:0][CNT_W-1:0] wb_idx;

  logic [NUM_SBOX-1:0][NIBBLE_W-1:0] sb_in1, sb_in2, sb_in3;
  logic [NUM_SBOX-1:0][NIBBLE_W-1:0] sb_out1, sb_out2, sb_out3;

  // Chunk select: instance j handles nibble issue_cnt*NUM_SBOX + j. The
  // counter stays on the last chunk after ISSUE, so without zeroization the
  // S-box inputs keep showing that chunk.
  always_comb begin
    for (int j = 0; j < NUM_SBOX; j++) begin
      sb_in1[j] = st_sh1[4'(int'(issue_cnt) * NUM_SBOX + j)];
      sb_in2[j] = st_sh2[4'(int'(issue_cnt) * NUM_SBOX + j)];
      sb_in3[j] = st_sh3[4'(int'(issue_cnt) * NUM_SBOX + j)];
`ifdef PRESENT_SBOX_LAYER_ZEROIZE_EN
      if (state != ISSUE) begin
        sb_in1[j] = '0;
        sb_in2[j] = '0;
        sb_in3[j] = '0;
      end
`endif
    end
  end

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    present_sbox_3sh u_sbox (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_sh1  (sb_in1[g]),
      .in_sh2  (sb_in2[g]),
      .in_sh3  (sb_in3[g]),
      .rnd     (rnd[RND_PER_SBOX*g +: RND_PER_SBOX]),
      .out_sh1 (sb_out1[g]),
      .out_sh2 (sb_out2[g]),
      .out_sh3 (sb_out3[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      drain_cnt <= '0;
      st_sh1    <= '0;
      st_sh2    <= '0;
      st_sh3    <= '0;
      out_r1    <= '0;
      out_r2    <= '0;
      out_r3    <= '0;
      wb_vld    <= '0;
      wb_idx    <= '0;
      rnd_req   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done   <= 1'b0;
      wb_vld <= {wb_vld[SBOX_LAT-2:0], (state == ISSUE)};
      wb_idx <= {wb_idx[SBOX_LAT-2:0], issue_cnt};

      if (wb_vld[SBOX_LAT-1]) begin
        for (int j = 0; j < NUM_SBOX; j++) begin
          out_r1[4'(int'(wb_idx[SBOX_LAT-1]) * NUM_SBOX + j)] <= sb_out1[j];
          out_r2[4'(int'(wb_idx[SBOX_LAT-1]) * NUM_SBOX + j)] <= sb_out2[j];
          out_r3[4'(int'(wb_idx[SBOX_LAT-1]) * NUM_SBOX + j)] <= sb_out3[j];
        end
        if (wb_idx[SBOX_LAT-1] == LAST_CHUNK) begin
          done <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          // done is still high in the first IDLE cycle; a start there is
          // dropped so the finished result is seen for at least one cycle.
          if (start && !done) begin
            st_sh1    <= in_sh1;
            st_sh2    <= in_sh2;
            st_sh3    <= in_sh3;
            issue_cnt <= '0;
            rnd_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
`ifdef PRESENT_SBOX_LAYER_ZEROIZE_EN
            out_r1    <= '0;
            out_r2    <= '0;
            out_r3    <= '0;
`endif
          end else if (done) begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          if (issue_cnt == LAST_CHUNK) begin
            rnd_req   <= 1'b0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            issue_cnt <= issue_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_sh1   = out_r1;
  assign out_sh2   = out_r2;
  assign out_sh3   = out_r3;
  assign state_dbg = state;

endmodule

// File: tb/tb_present_sbox_layer_3sh.sv
// -----------------------------------------------------------------------------
// tb_present_sbox_layer_3sh
// Three layer instances (NUM_SBOX = 16, 4, 2) on one clock. Directed vector
// table with hand-computed S-layer results, random vectors against a
// lookup-table model, and sequences for start-while-busy, start-in-done and
// reset-abort. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_present_sbox_layer_3sh;
  import present_masked_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0]        rst_a;
  logic [ND-1:0]        start_a;
  logic [ND-1:0][63:0]  i1, i2, i3;
  logic [127:0]         rnd16;
  logic [31:0]          rnd4;
  logic [15:0]          rnd2;
  logic [ND-1:0]        req_a, busy_a, done_a;
  logic [ND-1:0][63:0]  o1, o2, o3;
  logic [ND-1:0][1:0]   st_a;

  present_sbox_layer_3sh #(.NUM_SBOX(16)) dut16 (
    .clk(clk), .rst_n(rst_a[0]), .start(start_a[0]),
    .in_sh1(i1[0]), .in_sh2(i2[0]), .in_sh3(i3[0]), .rnd(rnd16),
    .rnd_req(req_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .out_sh1(o1[0]), .out_sh2(o2[0]), .out_sh3(o3[0]), .state_dbg(st_a[0]));

  present_sbox_layer_3sh #(.NUM_SBOX(4)) dut4 (
    .clk(clk), .rst_n(rst_a[1]), .start(start_a[1]),
    .in_sh1(i1[1]), .in_sh2(i2[1]), .in_sh3(i3[1]), .rnd(rnd4),
    .rnd_req(req_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .out_sh1(o1[1]), .out_sh2(o2[1]), .out_sh3(o3[1]), .state_dbg(st_a[1]));

  present_sbox_layer_3sh #(.NUM_SBOX(2)) dut2 (
    .clk(clk), .rst_n(rst_a[2]), .start(start_a[2]),
    .in_sh1(i1[2]), .in_sh2(i2[2]), .in_sh3(i3[2]), .rnd(rnd2),
    .rnd_req(req_a[2]), .busy(busy_a[2]), .done(done_a[2]),
    .out_sh1(o1[2]), .out_sh2(o2[2]), .out_sh3(o3[2]), .state_dbg(st_a[2]));

  // Scoreboard
  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] last_exp [ND];

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [3:0] sb(input logic [3:0] v);
    case (v)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sb(x[4*n +: 4]);
    return r;
  endfunction

  function automatic int ch_of(input logic [1:0] d);
    case (d)
      2'd0:    return 1;
      2'd1:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic set_rnd(input logic [1:0] d, input bit rand_mode);
    case (d)
      2'd0:    rnd16 = rand_mode ? {$urandom, $urandom, $urandom, $urandom} : '0;
      2'd1:    rnd4  = rand_mode ? $urandom : '0;
      default: rnd2  = rand_mode ? 16'($urandom) : '0;
    endcase
  endtask

  // One layer on instance d. repulse_at > 0 raises start again in cycle
  // T+repulse_at (must be ignored); abort_at > 0 pulls rst_n low in cycle
  // T+abort_at (no done, outputs cleared afterwards).
  task automatic run_layer(input logic [1:0] d, input logic [63:0] x,
                           input logic [63:0] exp, input bit rand_mode,
                           input int repulse_at, input int abort_at,
                           input string tag);
    int ch, window, done_cnt, done_at, req_bad, busy_bad, clear_bad;
    logic [63:0] m2, m3, got;
    ch = ch_of(d);
    window = ch + 8;
    done_cnt = 0; done_at = -1; req_bad = 0; busy_bad = 0; clear_bad = 0;
    got = '0;
    m2 = rand_mode ? rand64() : 64'h0;
    m3 = rand_mode ? rand64() : 64'h0;
    @(negedge clk);
    i2[d] = m2;
    i3[d] = m3;
    i1[d] = x ^ m2 ^ m3;
    start_a[d] = 1'b1;
    set_rnd(d, rand_mode);
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      if (c == 1) begin
`ifdef PRESENT_SBOX_LAYER_ZEROIZE_EN
        check({tag, "/zeroize"}, o1[d] | o2[d] | o3[d], 64'h0);
`else
        check({tag, "/hold_prev"}, o1[d] ^ o2[d] ^ o3[d], last_exp[d]);
`endif
      end
      if (abort_at == 0 || c <= abort_at) begin
        if (req_a[d] !== (c <= ch)) req_bad++;
        if (busy_a[d] !== (c <= ch + 4)) busy_bad++;
      end
      if (abort_at > 0 && c > abort_at) begin
        if ((o1[d] | o2[d] | o3[d]) !== 64'h0 || busy_a[d] !== 1'b0 ||
            req_a[d] !== 1'b0 || st_a[d] !== 2'(IDLE)) clear_bad++;
      end
      if (done_a[d] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          got = o1[d] ^ o2[d] ^ o3[d];
        end
      end
      start_a[d] = (c == repulse_at);
      i1[d] = rand64();
      i2[d] = rand64();
      i3[d] = rand64();
      rst_a[d] = (c != abort_at);
      set_rnd(d, rand_mode);
    end
    start_a[d] = 1'b0;
    rst_a[d] = 1'b1;
    if (abort_at > 0) begin
      check({tag, "/no_done"}, 64'(done_cnt), 64'd0);
      check({tag, "/abort_clear"}, 64'(clear_bad), 64'd0);
      check({tag, "/pre_abort_flags"}, 64'(req_bad + busy_bad), 64'd0);
      last_exp[d] = '0;
    end else begin
      check({tag, "/latency"}, 64'(done_at), 64'(ch + 4));
      check({tag, "/result"}, got, exp);
      check({tag, "/done_pulses"}, 64'(done_cnt), 64'd1);
      check({tag, "/rnd_req_window"}, 64'(req_bad), 64'd0);
      check({tag, "/busy_window"}, 64'(busy_bad), 64'd0);
      check({tag, "/result_held"}, o1[d] ^ o2[d] ^ o3[d], exp);
      last_exp[d] = exp;
    end
  endtask

  initial begin
    vecs[0] = '{x: 64'h0123456789ABCDEF, y: 64'hC56B90AD3EF84712};
    vecs[1] = '{x: 64'h0000000000000000, y: 64'hCCCCCCCCCCCCCCCC};
    vecs[2] = '{x: 64'hFFFFFFFFFFFFFFFF, y: 64'h2222222222222222};
    vecs[3] = '{x: 64'hFEDCBA9876543210, y: 64'h21748FE3DA09B65C};
    vecs[4] = '{x: 64'h5A5A5A5A5A5A5A5A, y: 64'h0F0F0F0F0F0F0F0F};
    for (int d = 0; d < ND; d++) last_exp[d] = '0;

    // Clock/reset
    rst_a = '0;
    start_a = '0;
    i1 = '0; i2 = '0; i3 = '0;
    rnd16 = '0; rnd4 = '0; rnd2 = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset%0d/flags", d),
            64'({req_a[d], busy_a[d], done_a[d]}), 64'd0);
      check($sformatf("reset%0d/outs", d), o1[d] | o2[d] | o3[d], 64'h0);
      check($sformatf("reset%0d/state", d), 64'(st_a[d]), 64'(IDLE));
    end
    rst_a = '1;
    @(negedge clk);

    // Unmasked vector, zero randomness
    run_layer(2'd0, 64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 1'b0, 0, 0, "plain16");

    // Directed table on every instance with random shares and randomness
    for (int d = 0; d < ND; d++) begin
      for (int v = 0; v < 5; v++) begin
        run_layer(2'(d), vecs[v].x, vecs[v].y, 1'b1, 0, 0,
                  $sformatf("tab_d%0d_v%0d", d, v));
      end
    end

    // Random vectors against the lookup model
    for (int n = 0; n < 1000; n++) begin
      logic [63:0] x;
      x = rand64();
      run_layer(2'd0, x, s_layer(x), 1'b1, 0, 0, $sformatf("rand%0d", n));
    end

    // start while busy, start in the done cycle
    run_layer(2'd1, 64'h0, 64'hCCCCCCCCCCCCCCCC, 1'b1, 2, 0, "busy_start4");
    run_layer(2'd0, vecs[3].x, vecs[3].y, 1'b1, 5, 0, "done_start16");
    run_layer(2'd1, vecs[0].x, vecs[0].y, 1'b1, 8, 0, "done_start4");

    // Reset abort and recovery
    run_layer(2'd2, vecs[0].x, vecs[0].y, 1'b1, 0, 3, "abort2");
    run_layer(2'd2, vecs[0].x, vecs[0].y, 1'b1, 0, 0, "after_abort2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
